// File: rtl/loong_pkg.sv
// Shared definitions for the state matrix loader: default geometry, cell type,
// loader FSM states and the fill-index to matrix-position mapping.
package loong_pkg;

  localparam int CELL_W_DEF = 4;
  localparam int DIM_DEF    = 4;

  typedef logic [CELL_W_DEF-1:0] cell_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD
  } state_t;

  // Row-major keeps p = k; column-major transposes, which is its own inverse,
  // so the same function also maps a position back to its fill index.
  function automatic int fill_pos(input int k, input int col_major, input int dim = DIM_DEF);
    if (col_major != 0) begin
      return (k % dim) * dim + (k / dim);
    end
    return k;
  endfunction

endpackage

// File: rtl/matrix_lane_writer.sv
// Staging register plus one DIM x DIM cell matrix; each write beat fills the
// LANES cells whose fill index falls in the current beat. Optional: KEY_XOR_EN.
module matrix_lane_writer
  import loong_pkg::*;
#(
  parameter int CELL_W    = CELL_W_DEF,
  parameter int DIM       = DIM_DEF,
  parameter int LANES     = 4,
  parameter int COL_MAJOR = 0,
  parameter int CNT_W     = 3
) (
  input  logic                      clck,
  input  logic                      rst,
  input  logic                      capture_en,
  input  logic                      write_en,
  input  logic [CNT_W-1:0]          cnt,
  input  logic [DIM*DIM*CELL_W-1:0] data_in,
  output logic [DIM*DIM*CELL_W-1:0] matrix
`ifdef KEY_XOR_EN
  ,
  output logic [DIM*DIM*CELL_W-1:0] matrix_next
`endif
);

  localparam int N = DIM * DIM;
  localparam int W = N * CELL_W;

  logic [W-1:0] stage_q, stage_d;
  logic [W-1:0] matrix_q, matrix_d;
  logic [W-1:0] src_cells;
  logic [N-1:0] hit;

  // Each position statically knows its fill index, hence its beat and source cell.
  for (genvar gi = 0; gi < N; gi++) begin : g_cell
    localparam int K   = fill_pos(gi, COL_MAJOR, DIM);
    localparam int SRC = N - 1 - K;
    localparam logic [CNT_W-1:0] BEAT = CNT_W'(K / LANES);
    assign hit[gi] = write_en && (cnt == BEAT);
    assign src_cells[gi*CELL_W +: CELL_W] = stage_q[SRC*CELL_W +: CELL_W];
  end

  always_comb begin
    stage_d = stage_q;
    if (capture_en) begin
      stage_d = data_in;
    end
  end

  always_comb begin
    matrix_d = matrix_q;
    for (int p = 0; p < N; p++) begin
      if (hit[p]) begin
        matrix_d[p*CELL_W +: CELL_W] = src_cells[p*CELL_W +: CELL_W];
      end
    end
  end

  always_ff @(posedge clck) begin
    if (!rst) begin
      stage_q  <= '0;
      matrix_q <= '0;
    end else begin
      stage_q  <= stage_d;
      matrix_q <= matrix_d;
    end
  end

  assign matrix = matrix_q;
`ifdef KEY_XOR_EN
  assign matrix_next = matrix_d;
`endif

endmodule

// File: rtl/state_matrix_loader.sv
// Loads a text block and round key into DIM x DIM matrices, LANES cells per cycle,
// and holds them under out_valid/out_ready. Optional: KEY_XOR_EN adds xk_matrix.
module state_matrix_loader
  import loong_pkg::*;
#(
  parameter int CELL_W    = CELL_W_DEF,
  parameter int DIM       = DIM_DEF,
  parameter int LANES     = 4,
  parameter int COL_MAJOR = 0
) (
  input  logic                      clck,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIM*DIM*CELL_W-1:0] text_in,
  input  logic [DIM*DIM*CELL_W-1:0] key_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIM*DIM*CELL_W-1:0] txt_matrix,
  output logic [DIM*DIM*CELL_W-1:0] key_matrix,
  output logic                      busy
`ifdef KEY_XOR_EN
  ,
  output logic [DIM*DIM*CELL_W-1:0] xk_matrix
`endif
);

  localparam int N     = DIM * DIM;
  localparam int W     = N * CELL_W;
  localparam int BEATS = N / LANES;
  localparam int CNT_W = $clog2(BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if ((LANES < 1) || (N % LANES != 0)) begin : g_bad_lanes
    $error("state_matrix_loader: LANES must divide DIM*DIM");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             capture_en;
  logic             write_en;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture_en = 1'b0;
    write_en   = 1'b0;
    in_ready   = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture_en = 1'b1;
          cnt_d      = '0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        busy     = 1'b1;
        write_en = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BEAT) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clck) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef KEY_XOR_EN
  logic [W-1:0] txt_next, key_next;
  logic [W-1:0] xk_q, xk_d;
`endif

  matrix_lane_writer #(
    .CELL_W   (CELL_W),
    .DIM      (DIM),
    .LANES    (LANES),
    .COL_MAJOR(COL_MAJOR),
    .CNT_W    (CNT_W)
  ) u_txt (
    .clck       (clck),
    .rst        (rst),
    .capture_en (capture_en),
    .write_en   (write_en),
    .cnt        (cnt_q),
    .data_in    (text_in),
    .matrix     (txt_matrix)
`ifdef KEY_XOR_EN
    ,
    .matrix_next(txt_next)
`endif
  );

  matrix_lane_writer #(
    .CELL_W   (CELL_W),
    .DIM      (DIM),
    .LANES    (LANES),
    .COL_MAJOR(COL_MAJOR),
    .CNT_W    (CNT_W)
  ) u_key (
    .clck       (clck),
    .rst        (rst),
    .capture_en (capture_en),
    .write_en   (write_en),
    .cnt        (cnt_q),
    .data_in    (key_in),
    .matrix     (key_matrix)
`ifdef KEY_XOR_EN
    ,
    .matrix_next(key_next)
`endif
  );

`ifdef KEY_XOR_EN
  // Unwritten cells already hold txt^key, so XORing the whole next matrices is exact.
  always_comb begin
    xk_d = xk_q;
    if (write_en) begin
      xk_d = txt_next ^ key_next;
    end
  end

  always_ff @(posedge clck) begin
    if (!rst) begin
      xk_q <= '0;
    end else begin
      xk_q <= xk_d;
    end
  end

  assign xk_matrix = xk_q;
`endif

endmodule

// File: tb/tb_state_matrix_loader.sv
// Drives three loader instances (row/4 lanes, column/2 lanes, row/16 lanes) from
// shared stimulus; a transaction-level model is compared every cycle.
module tb_state_matrix_loader;
  import loong_pkg::*;

  localparam int N  = 16;
  localparam int W  = 64;
  localparam int NI = 3;

  function automatic int lanes_of(input int i);
    case (i)
      0:       return 4;
      1:       return 2;
      default: return 16;
    endcase
  endfunction

  function automatic int colm_of(input int i);
    return (i == 1) ? 1 : 0;
  endfunction

  logic clck = 1'b0;
  always #5 clck = ~clck;

  logic          rst;
  logic          in_valid;
  logic [W-1:0]  text_in, key_in;
  logic [NI-1:0] out_ready;
  logic [NI-1:0] in_ready_w, out_valid_w, busy_w;
  logic [W-1:0]  txt_w [NI];
  logic [W-1:0]  key_w [NI];
`ifdef KEY_XOR_EN
  logic [W-1:0]  xk_w [NI];
`endif

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    state_matrix_loader #(
      .CELL_W   (4),
      .DIM      (4),
      .LANES    (lanes_of(gi)),
      .COL_MAJOR(colm_of(gi))
    ) dut (
      .clck      (clck),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[gi]),
      .text_in   (text_in),
      .key_in    (key_in),
      .out_valid (out_valid_w[gi]),
      .out_ready (out_ready[gi]),
      .txt_matrix(txt_w[gi]),
      .key_matrix(key_w[gi]),
      .busy      (busy_w[gi])
`ifdef KEY_XOR_EN
      ,
      .xk_matrix (xk_w[gi])
`endif
    );
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Writes fill indices [k_lo, k_hi) straight from the r/c formulas.
  function automatic logic [W-1:0] scatter(input logic [W-1:0] cur, input logic [W-1:0] src,
                                           input int k_lo, input int k_hi, input int colm);
    logic [W-1:0] res;
    res = cur;
    for (int k = k_lo; k < k_hi; k++) begin
      int s, r, c, p;
      s = N - 1 - k;
      if (colm != 0) begin
        r = k % 4;
        c = k / 4;
      end else begin
        r = k / 4;
        c = k % 4;
      end
      p = r * 4 + c;
      res[p*4 +: 4] = src[s*4 +: 4];
    end
    return res;
  endfunction

  logic [W-1:0] m_txt [NI];
  logic [W-1:0] m_key [NI];
  logic [W-1:0] m_stxt [NI];
  logic [W-1:0] m_skey [NI];
  int           m_done [NI];
  bit           m_load [NI];
  bit           m_hold [NI];

  always @(posedge clck) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst) begin
        m_txt[i]  <= '0;
        m_key[i]  <= '0;
        m_stxt[i] <= '0;
        m_skey[i] <= '0;
        m_done[i] <= 0;
        m_load[i] <= 1'b0;
        m_hold[i] <= 1'b0;
      end else if (m_load[i]) begin
        m_txt[i]  <= scatter(m_txt[i], m_stxt[i], m_done[i] * lanes_of(i),
                             (m_done[i] + 1) * lanes_of(i), colm_of(i));
        m_key[i]  <= scatter(m_key[i], m_skey[i], m_done[i] * lanes_of(i),
                             (m_done[i] + 1) * lanes_of(i), colm_of(i));
        m_done[i] <= m_done[i] + 1;
        if ((m_done[i] + 1) * lanes_of(i) == N) begin
          m_load[i] <= 1'b0;
          m_hold[i] <= 1'b1;
        end
      end else if (m_hold[i]) begin
        if (out_ready[i]) m_hold[i] <= 1'b0;
      end else if (in_valid) begin
        m_stxt[i] <= text_in;
        m_skey[i] <= key_in;
        m_done[i] <= 0;
        m_load[i] <= 1'b1;
      end
    end
  end

  always @(negedge clck) begin
    if (check_en) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("in_ready[%0d]", i), W'(in_ready_w[i]), W'(!m_load[i] && !m_hold[i]));
        check($sformatf("busy[%0d]", i), W'(busy_w[i]), W'(m_load[i]));
        check($sformatf("out_valid[%0d]", i), W'(out_valid_w[i]), W'(m_hold[i]));
        check($sformatf("txt_matrix[%0d]", i), txt_w[i], m_txt[i]);
        check($sformatf("key_matrix[%0d]", i), key_w[i], m_key[i]);
`ifdef KEY_XOR_EN
        check($sformatf("xk_matrix[%0d]", i), xk_w[i], m_txt[i] ^ m_key[i]);
`endif
      end
    end
  end

  localparam logic [W-1:0] TEXT1   = 64'h0123_4567_89AB_CDEF;
  localparam logic [W-1:0] ROW_EXP = 64'hFEDC_BA98_7654_3210;
  localparam logic [W-1:0] COL_EXP = 64'hFB73_EA62_D951_C840;
  localparam logic [W-1:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] KEY4    = 64'h1111_2222_3333_4444;

  int first_v [NI];
  int busy_n  [NI];
  int acc_n   [NI];

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    text_in   = '0;
    key_in    = '0;
    out_ready = '0;
    repeat (3) @(negedge clck);
    check_en = 1'b1;
    rst      = 1'b1;
    @(negedge clck);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset in_ready[%0d]", i), W'(in_ready_w[i]), W'(1));
      check($sformatf("reset out_valid[%0d]", i), W'(out_valid_w[i]), W'(0));
      check($sformatf("reset busy[%0d]", i), W'(busy_w[i]), W'(0));
      check($sformatf("reset txt[%0d]", i), txt_w[i], '0);
      check($sformatf("reset key[%0d]", i), key_w[i], '0);
    end

    // Latency, fill order and backpressure with ignored in_valid pulses.
    text_in  = TEXT1;
    key_in   = '0;
    in_valid = 1'b1;
    for (int i = 0; i < NI; i++) begin
      first_v[i] = -1;
      busy_n[i]  = 0;
    end
    for (int j = 0; j < 14; j++) begin
      @(negedge clck);
      for (int i = 0; i < NI; i++) begin
        if (busy_w[i]) busy_n[i]++;
        if (out_valid_w[i] && first_v[i] < 0) first_v[i] = j;
      end
      if (j == 10) begin
        for (int i = 0; i < NI; i++) begin
          check($sformatf("hold in_ready[%0d]", i), W'(in_ready_w[i]), W'(0));
          check($sformatf("hold out_valid[%0d]", i), W'(out_valid_w[i]), W'(1));
        end
      end
      if (j == 0) in_valid = 1'b0;
      if (j >= 5 && j <= 7) begin
        in_valid = 1'b1;
        text_in  = {$urandom, $urandom};
        key_in   = {$urandom, $urandom};
      end
      if (j == 8) in_valid = 1'b0;
    end
    for (int i = 0; i < NI; i++) begin
      check($sformatf("latency[%0d]", i), W'(first_v[i]), W'(N / lanes_of(i)));
      check($sformatf("busy_cycles[%0d]", i), W'(busy_n[i]), W'(N / lanes_of(i)));
      check($sformatf("txt_literal[%0d]", i), txt_w[i], (colm_of(i) != 0) ? COL_EXP : ROW_EXP);
      check($sformatf("key_zero[%0d]", i), key_w[i], '0);
    end
    out_ready = '1;
    @(negedge clck);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("release out_valid[%0d]", i), W'(out_valid_w[i]), W'(0));
      check($sformatf("release in_ready[%0d]", i), W'(in_ready_w[i]), W'(1));
    end

    // All-ones key: key matrix all ones, xk is the bit-inverted text matrix.
    out_ready = '0;
    text_in   = TEXT1;
    key_in    = ONES;
    in_valid  = 1'b1;
    @(negedge clck);
    in_valid = 1'b0;
    repeat (9) @(negedge clck);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("ones out_valid[%0d]", i), W'(out_valid_w[i]), W'(1));
      check($sformatf("ones key[%0d]", i), key_w[i], ONES);
    end
`ifdef KEY_XOR_EN
    check("xk_literal_row", xk_w[0], TEXT1);
    check("xk_literal_col", xk_w[1], 64'h048C_159D_26AE_37BF);
`endif
    out_ready = '1;
    @(negedge clck);

    // Reset on the second LOAD edge, then a clean block.
    out_ready = '0;
    text_in   = TEXT1;
    key_in    = KEY4;
    in_valid  = 1'b1;
    @(negedge clck);
    in_valid = 1'b0;
    @(negedge clck);
    rst = 1'b0;
    @(negedge clck);
    check("abort txt", txt_w[0], '0);
    check("abort key", key_w[0], '0);
    check("abort out_valid", W'(out_valid_w[0]), W'(0));
    check("abort in_ready", W'(in_ready_w[0]), W'(1));
    rst      = 1'b1;
    in_valid = 1'b1;
    @(negedge clck);
    in_valid = 1'b0;
    repeat (9) @(negedge clck);
    check("after_abort txt", txt_w[0], ROW_EXP);
    check("after_abort key", key_w[0], 64'h4444_3333_2222_1111);
    check("after_abort out_valid", W'(out_valid_w[0]), W'(1));
    out_ready = '1;
    @(negedge clck);

    // Throughput with in_valid and out_ready tied high.
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clck);
    rst      = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < NI; i++) acc_n[i] = 0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clck);
      for (int i = 0; i < NI; i++) begin
        if (in_ready_w[i]) acc_n[i]++;
      end
      text_in = {$urandom, $urandom};
      key_in  = {$urandom, $urandom};
    end
    for (int i = 0; i < NI; i++) begin
      check($sformatf("throughput[%0d]", i), W'(acc_n[i]), W'(60 / (N / lanes_of(i) + 2)));
    end

    // Randomized traffic with occasional resets.
    for (int t = 0; t < 3000; t++) begin
      @(negedge clck);
      rst       = ($urandom_range(0, 99) != 0);
      in_valid  = ($urandom_range(0, 1) == 1);
      text_in   = {$urandom, $urandom};
      key_in    = {$urandom, $urandom};
      out_ready = NI'($urandom_range(0, 7));
    end
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clck);
    @(negedge clck);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
